// File: rtl/seg_scan_controller_pkg.sv
// Shared segment constants and scan-slot state encoding for the display scan path.
// Segment patterns are active-low, ordered {dp,g,f,e,d,c,b,a}.
package seg_scan_controller_pkg;

    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_DP   = 8'h7F;

    typedef enum logic {
        S_DEAD = 1'b0,
        S_ON   = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_scan_controller_if.sv
// Display data from the timekeeping core and the multiplexed pin-side outputs.
interface seg_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_bcd;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    blank_leading;
    logic [NUM_DIGITS-1:0]   which_light;
    logic [7:0]              digit_shape;
    logic                    frame_done;

    modport master (
        output digits_bcd, dp_mask, blink_mask, blank_leading,
        input  which_light, digit_shape, frame_done
    );

    modport slave (
        input  digits_bcd, dp_mask, blink_mask, blank_leading,
        output which_light, digit_shape, frame_done
    );
endinterface

// File: rtl/seg_scan_controller_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; codes above 9 show a dash, dp always off.
module seg_scan_controller_bcd_to_seg
    import seg_scan_controller_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 7-segment scan scheduler with dead time, blinking,
// leading-zero blanking and decimal points. All outputs registered.
//
// state  | meaning
// S_DEAD | slot start, all digits off (ghost suppression)
// S_ON   | current digit driven unless blanked
module seg_scan_controller
    import seg_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 4,
    parameter int DEAD_CYCLES = 1,
    parameter int BLINK_DIV   = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    seg_scan_controller_if.slave disp
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LIM   = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam scan_state_e   STATE_RST  = (DEAD_CYCLES > 0) ? S_DEAD : S_ON;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    scan_state_e             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
    logic                    snap_blank_q, snap_blank_d;
    logic [NUM_DIGITS-1:0]   which_q, which_d;
    logic [7:0]              shape_q, shape_d;
    logic                    frame_done_q, frame_done_d;

    logic                    frame_start;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    zero_acc;
    logic                    lead_blank;
    logic [3:0]              cur_bcd;
    logic [7:0]              cur_seg;

    seg_scan_controller_bcd_to_seg u_dec (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    // At the frame start the live inputs are used directly so that the first
    // slot already reflects the snapshot being taken, even with no dead time.
    always_comb begin
        frame_start  = (cnt_q == '0) && (idx_q == '0);
        snap_bcd_d   = frame_start ? disp.digits_bcd    : snap_bcd_q;
        snap_dp_d    = frame_start ? disp.dp_mask       : snap_dp_q;
        snap_blink_d = frame_start ? disp.blink_mask    : snap_blink_q;
        snap_blank_d = frame_start ? disp.blank_leading : snap_blank_q;
        cur_bcd      = snap_bcd_d[{idx_q, 2'b00} +: 4];

        zero_from = '0;
        zero_acc  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_acc     = zero_acc & (snap_bcd_d[4*i +: 4] == 4'd0);
            zero_from[i] = zero_acc;
        end
        lead_blank = snap_blank_d & zero_from[idx_q];
    end

    always_comb begin
        cnt_d         = cnt_q + CW'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        state_d = (cnt_d < DEAD_LIM) ? S_DEAD : S_ON;
    end

    always_comb begin
        which_d      = '0;
        shape_d      = SEG_OFF;
        frame_done_d = (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
        case (state_q)
            S_ON: begin
                if (!(blink_phase_q && snap_blink_d[idx_q])) begin
                    if (lead_blank) begin
                        // A blanked leading digit may still carry its decimal point.
                        if (snap_dp_d[idx_q]) begin
                            which_d[idx_q] = 1'b1;
                            shape_d        = SEG_DP;
                        end
                    end else begin
                        which_d[idx_q] = 1'b1;
                        shape_d        = cur_seg & (snap_dp_d[idx_q] ? SEG_DP : SEG_OFF);
                    end
                end
            end
            default: begin
                which_d = '0;
                shape_d = SEG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            state_q       <= STATE_RST;
            snap_bcd_q    <= '0;
            snap_dp_q     <= '0;
            snap_blink_q  <= '0;
            snap_blank_q  <= 1'b0;
            which_q       <= '0;
            shape_q       <= SEG_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            state_q       <= state_d;
            snap_bcd_q    <= snap_bcd_d;
            snap_dp_q     <= snap_dp_d;
            snap_blink_q  <= snap_blink_d;
            snap_blank_q  <= snap_blank_d;
            which_q       <= which_d;
            shape_q       <= shape_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign disp.which_light = which_q;
    assign disp.digit_shape = shape_q;
    assign disp.frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: driver pushes expected slot outputs,
// monitor pops and compares on the falling edge.
module tb_seg_scan_controller;

    typedef struct packed {
        int         cyc;
        logic [3:0] which;
        logic [7:0] shape;
        logic       fd;
    } exp_t;

    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF
    };

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seg_scan_controller_if #(.NUM_DIGITS(4)) disp ();

    seg_scan_controller dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp)
    );

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int e = 0;

    logic [15:0] s_bcd;
    logic [3:0]  s_dp, s_bm;
    logic        s_bl;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp, m_bm;
    logic        m_bl;

    task automatic drive(input logic [15:0] bcd, input logic [3:0] dp,
                         input logic [3:0] bm, input logic bl);
        s_bcd = bcd; s_dp = dp; s_bm = bm; s_bl = bl;
        disp.digits_bcd    = bcd;
        disp.dp_mask       = dp;
        disp.blink_mask    = bm;
        disp.blank_leading = bl;
    endtask

    // Expected output for cycle ec counted from reset release (latency 1 edge).
    function automatic exp_t model(input int ec);
        exp_t r;
        int   cnt, idx;
        logic lead, phase;
        r.cyc   = ec;
        r.which = '0;
        r.shape = 8'hFF;
        r.fd    = (ec % 16) == 15;
        cnt     = ec % 4;
        idx     = (ec / 4) % 4;
        phase   = ((ec / 500) % 2) == 1;
        if (cnt >= 1 && !(phase && m_bm[idx])) begin
            lead = m_bl && (idx >= 1);
            for (int i = idx; i < 4; i++)
                if (m_bcd[4*i +: 4] != 4'd0) lead = 1'b0;
            if (lead) begin
                if (m_dp[idx]) begin
                    r.which[idx] = 1'b1;
                    r.shape      = 8'h7F;
                end
            end else begin
                r.which[idx] = 1'b1;
                r.shape      = SEG_TAB[m_bcd[4*idx +: 4]] & (m_dp[idx] ? 8'h7F : 8'hFF);
            end
        end
        return r;
    endfunction

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (e % 16 == 0) begin
                m_bcd = s_bcd; m_dp = s_dp; m_bm = s_bm; m_bl = s_bl;
            end
            q.push_back(model(e));
            e++;
        end
    endtask

    task automatic run_to_frame_pos(input int pos);
        run(((pos - (e % 16)) + 16) % 16 == 0 ? 16 : ((pos - (e % 16)) + 16) % 16);
    endtask

    task automatic chk_idle(input string tag);
        checks++;
        if (disp.which_light !== 4'b0000 || disp.digit_shape !== 8'hFF || disp.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s got which=%b shape=%h fd=%b want which=0000 shape=ff fd=0",
                     tag, disp.which_light, disp.digit_shape, disp.frame_done);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (disp.which_light !== x.which || disp.digit_shape !== x.shape ||
                    disp.frame_done !== x.fd) begin
                    errors++;
                    $display("FAIL scan cyc=%0d got which=%b shape=%h fd=%b want which=%b shape=%h fd=%b",
                             x.cyc, disp.which_light, disp.digit_shape, disp.frame_done,
                             x.which, x.shape, x.fd);
                end
            end
        end
    end

    initial begin
        drive(16'h1234, 4'b0000, 4'b0000, 1'b0);
        #12;
        chk_idle("reset_state");
        @(negedge clk);
        reset = 1'b1;
        e = 0;
        // plain scan of 1234
        run(32);
        // leading-zero blanking
        #1 drive(16'h0045, 4'b0000, 4'b0000, 1'b1);
        run(32);
        #1 drive(16'h0000, 4'b0000, 4'b0000, 1'b1);
        run(32);
        #1 drive(16'h0000, 4'b1000, 4'b0000, 1'b1);
        run(16);
        #1 drive(16'h0000, 4'b0000, 4'b0000, 1'b0);
        run(32);
        // blinking digits 3,2 across several half-periods
        #1 drive(16'h1234, 4'b0000, 4'b1100, 1'b0);
        run(2000);
        // mid-frame change during digit 1 slot must not tear
        #1 drive(16'h1234, 4'b0000, 4'b0000, 1'b0);
        run_to_frame_pos(6);
        #1 drive(16'h5678, 4'b0000, 4'b0000, 1'b0);
        run(32);
        // dash with decimal point
        #1 drive(16'h0A00, 4'b0100, 4'b0000, 1'b0);
        run(32);
        // reset mid-ON of digit 2
        run_to_frame_pos(10);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_idle("async_reset");
        drive(16'h1234, 4'b0001, 4'b0000, 1'b0);
        @(negedge clk);
        chk_idle("reset_held");
        reset = 1'b1;
        e = 0;
        run(32);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
